ein_mon: RTL

- Receive-side monitor for the EIN 3-wire pad protocol (EMO/EDI/ECI) that ein_int drives.
- Samples the three pad lines and rebuilds bytes MSB-first.
- Presents each rebuilt frame to a bus_interface instance as a producer-side out_frame stream (data, latch pulse, frame valid).
- Used for loopback checking and for capturing EIN traffic from an external master.

---
 rtl/ein_mon.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/ein_mon.sv
// Receive-side monitor for the EIN 3-wire pad protocol: rebuilds MSB-first bytes into an out_frame stream.
// Optional status trailer byte at frame end is enabled with `define EIN_MON_STATUS_TRAILER_EN.
module ein_mon #(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 40000,
   parameter int TO_WIDTH       = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       EMO_PAD,
   input  logic       EDI_PAD,
   input  logic       ECI_PAD,
   output logic [7:0] out_frame_data,
   output logic       out_frame_data_latch,
   output logic       out_frame_valid,
   output logic       frame_done,
   output logic       frame_error,
   output logic [7:0] byte_count
);

   typedef enum logic [1:0] {
      WAIT_IDLE = 2'd0,
      IDLE      = 2'd1,
      FRAME     = 2'd2,
      END       = 2'd3
   } state_t;

   localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(TIMEOUT_CYCLES);
   localparam logic [TO_WIDTH-1:0] SETTLE   = TO_WIDTH'(SYNC_STAGES);
   localparam logic [TO_WIDTH-1:0] TO_ONE   = TO_WIDTH'(1);

   logic [SYNC_STAGES-1:0] emo_sync_q, emo_sync_d;
   logic [SYNC_STAGES-1:0] edi_sync_q, edi_sync_d;
   logic [SYNC_STAGES-1:0] eci_sync_q, eci_sync_d;
   logic                   emo_prev_q, emo_prev_d;
   logic                   eci_prev_q, eci_prev_d;

   state_t                 state_q, state_d;
   logic [6:0]             shreg_q, shreg_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [TO_WIDTH-1:0]    to_cnt_q, to_cnt_d;
   logic [7:0]             data_q, data_d;
   logic                   latch_q, latch_d;
   logic                   valid_q, valid_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;
   logic [7:0]             bcnt_q, bcnt_d;
`ifdef EIN_MON_STATUS_TRAILER_EN
   logic                   tflag_q, tflag_d;
`endif

   logic                   emo_s, edi_s, eci_s;
   logic                   eci_edge, emo_rise, emo_fall;
   logic [7:0]             byte_nx;
   logic [7:0]             bcnt_inc;

   assign emo_s    = emo_sync_q[SYNC_STAGES-1];
   assign edi_s    = edi_sync_q[SYNC_STAGES-1];
   assign eci_s    = eci_sync_q[SYNC_STAGES-1];
   assign eci_edge = eci_s ^ eci_prev_q;
   assign emo_rise = emo_s & ~emo_prev_q;
   assign emo_fall = ~emo_s & emo_prev_q;
   assign byte_nx  = {shreg_q, edi_s};
   assign bcnt_inc = (bcnt_q != 8'hFF) ? bcnt_q + 8'd1 : bcnt_q;

   always_comb begin
      emo_sync_d = {emo_sync_q[SYNC_STAGES-2:0], EMO_PAD};
      edi_sync_d = {edi_sync_q[SYNC_STAGES-2:0], EDI_PAD};
      eci_sync_d = {eci_sync_q[SYNC_STAGES-2:0], ECI_PAD};
      emo_prev_d = emo_s;
      eci_prev_d = eci_s;
   end

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      to_cnt_d  = to_cnt_q;
      data_d    = data_q;
      latch_d   = 1'b0;
      valid_d   = valid_q;
      done_d    = 1'b0;
      err_d     = err_q;
      bcnt_d    = bcnt_q;
`ifdef EIN_MON_STATUS_TRAILER_EN
      tflag_d   = tflag_q;
`endif
      case (state_q)
         // The synchronizers come out of reset at 0 regardless of the pads, so
         // wait until the chain has refilled before trusting EMO_s low.
         WAIT_IDLE: begin
            if (to_cnt_q < SETTLE) begin
               to_cnt_d = to_cnt_q + TO_ONE;
            end else if (!emo_s) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            if (emo_rise) begin
               state_d   = FRAME;
               bit_cnt_d = 3'd0;
               bcnt_d    = 8'd0;
               err_d     = 1'b0;
               to_cnt_d  = '0;
               valid_d   = 1'b1;
`ifdef EIN_MON_STATUS_TRAILER_EN
               tflag_d   = 1'b0;
`endif
            end
         end
         FRAME: begin
            if (eci_edge) begin
               shreg_d   = byte_nx[6:0];
               bit_cnt_d = bit_cnt_q + 3'd1;
               to_cnt_d  = '0;
               if (bit_cnt_q == 3'd7) begin
                  data_d  = byte_nx;
                  latch_d = 1'b1;
                  bcnt_d  = bcnt_inc;
               end
            end else if (to_cnt_q != TO_LIMIT) begin
               to_cnt_d = to_cnt_q + TO_ONE;
            end
            // A bit arriving with the EMO fall is accepted before the residue check.
            if (emo_fall) begin
               if (bit_cnt_d != 3'd0) begin
                  err_d = 1'b1;
               end
               state_d = END;
`ifndef EIN_MON_STATUS_TRAILER_EN
               valid_d = 1'b0;
               done_d  = 1'b1;
`endif
            end else if (!eci_edge && (to_cnt_q >= TO_LIMIT)) begin
               err_d   = 1'b1;
               state_d = END;
`ifdef EIN_MON_STATUS_TRAILER_EN
               tflag_d = 1'b1;
`else
               valid_d = 1'b0;
               done_d  = 1'b1;
`endif
            end
         end
         END: begin
            state_d  = WAIT_IDLE;
            to_cnt_d = '0;
`ifdef EIN_MON_STATUS_TRAILER_EN
            data_d   = {err_q, tflag_q, 3'b000, bit_cnt_q};
            latch_d  = 1'b1;
            valid_d  = 1'b0;
            done_d   = 1'b1;
`endif
         end
         default: begin
            state_d = WAIT_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         emo_sync_q <= '0;
         edi_sync_q <= '0;
         eci_sync_q <= '0;
         emo_prev_q <= 1'b0;
         eci_prev_q <= 1'b0;
         state_q    <= WAIT_IDLE;
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         to_cnt_q   <= '0;
         data_q     <= '0;
         latch_q    <= 1'b0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         bcnt_q     <= '0;
`ifdef EIN_MON_STATUS_TRAILER_EN
         tflag_q    <= 1'b0;
`endif
      end else begin
         emo_sync_q <= emo_sync_d;
         edi_sync_q <= edi_sync_d;
         eci_sync_q <= eci_sync_d;
         emo_prev_q <= emo_prev_d;
         eci_prev_q <= eci_prev_d;
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bit_cnt_q  <= bit_cnt_d;
         to_cnt_q   <= to_cnt_d;
         data_q     <= data_d;
         latch_q    <= latch_d;
         valid_q    <= valid_d;
         done_q     <= done_d;
         err_q      <= err_d;
         bcnt_q     <= bcnt_d;
`ifdef EIN_MON_STATUS_TRAILER_EN
         tflag_q    <= tflag_d;
`endif
      end
   end

   assign out_frame_data       = data_q;
   assign out_frame_data_latch = latch_q;
   assign out_frame_valid      = valid_q;
   assign frame_done           = done_q;
   assign frame_error          = err_q;
   assign byte_count           = bcnt_q;

endmodule
